// File: rtl/game_pkg.sv
// +-----------------------------------------------------------------------+
// | game_pkg: shared state/screen codes and default game constants        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package game_pkg;

  typedef enum logic [2:0] {
    ST_TITLE     = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_LIFE_LOST = 3'd4,
    ST_WIN       = 3'd5,
    ST_GAME_OVER = 3'd6
  } game_state_t;

  // Screen codes consumed by the top-level RGB mux.
  localparam logic [2:0] C_SCR_TITLE     = 3'd0;
  localparam logic [2:0] C_SCR_COUNTDOWN = 3'd1;
  localparam logic [2:0] C_SCR_PLAYING   = 3'd2;
  localparam logic [2:0] C_SCR_PAUSED    = 3'd3;
  localparam logic [2:0] C_SCR_LIFE_LOST = 3'd4;
  localparam logic [2:0] C_SCR_WIN       = 3'd5;
  localparam logic [2:0] C_SCR_GAME_OVER = 3'd6;

  localparam int C_LIVES_INIT       = 3;
  localparam int C_MAX_LEVEL        = 4;
  localparam int C_COUNTDOWN_FRAMES = 180;
  localparam int C_LIFE_LOST_FRAMES = 120;
  localparam int C_FRAME_END_Y      = 481;

  function automatic logic [2:0] screen_code(input game_state_t s);
    logic [2:0] code;
    code = C_SCR_TITLE;
    case (s)
      ST_TITLE:     code = C_SCR_TITLE;
      ST_COUNTDOWN: code = C_SCR_COUNTDOWN;
      ST_PLAYING:   code = C_SCR_PLAYING;
      ST_PAUSED:    code = C_SCR_PAUSED;
      ST_LIFE_LOST: code = C_SCR_LIFE_LOST;
      ST_WIN:       code = C_SCR_WIN;
      ST_GAME_OVER: code = C_SCR_GAME_OVER;
      default:      code = C_SCR_TITLE;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_flow_ctrl_if.sv
// +-----------------------------------------------------------------------+
// | game_flow_ctrl_if: timing/event inputs and sequencer outputs          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface game_flow_ctrl_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       game_start;
  logic       pause;
  logic       player_hit;
  logic       wave_cleared;
  logic [2:0] screen_sel;
  logic       game_run;
  logic       game_reset;
  logic [1:0] lives;
  logic [2:0] level;
  logic [7:0] countdown;
  logic       frame_tick;

  modport master (
    output p_tick, x, y, game_start, pause, player_hit, wave_cleared,
    input  screen_sel, game_run, game_reset, lives, level, countdown, frame_tick
  );

  modport slave (
    input  p_tick, x, y, game_start, pause, player_hit, wave_cleared,
    output screen_sel, game_run, game_reset, lives, level, countdown, frame_tick
  );
endinterface

`default_nettype wire

// File: rtl/frame_event_latch.sv
// +-----------------------------------------------------------------------+
// | frame_event_latch: sticky hit/clear flags, cleared every frame strobe |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module frame_event_latch (
  input  wire  clk,
  input  wire  rst,
  input  wire  i_frame_tick,
  input  wire  i_armed,
  input  wire  i_player_hit,
  input  wire  i_wave_cleared,
  output logic o_hit,
  output logic o_clr
);

  logic r_hit_f;
  logic r_clr_f;
  logic w_hit_pulse;
  logic w_clr_pulse;

  // Pulses only count while the game is actively running.
  assign w_hit_pulse = i_armed & i_player_hit;
  assign w_clr_pulse = i_armed & i_wave_cleared;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_f <= 1'b0;
      r_clr_f <= 1'b0;
    end else if (i_frame_tick) begin
      r_hit_f <= 1'b0;
      r_clr_f <= 1'b0;
    end else begin
      if (w_hit_pulse) r_hit_f <= 1'b1;
      if (w_clr_pulse) r_clr_f <= 1'b1;
    end
  end

  // A pulse landing on the strobe cycle itself still belongs to this frame.
  assign o_hit = r_hit_f | w_hit_pulse;
  assign o_clr = r_clr_f | w_clr_pulse;

endmodule

`default_nettype wire

// File: rtl/game_flow_ctrl.sv
// +-----------------------------------------------------------------------+
// | game_flow_ctrl: frame-synchronous game state machine, lives/level     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT       = C_LIVES_INIT,
  parameter int MAX_LEVEL        = C_MAX_LEVEL,
  parameter int COUNTDOWN_FRAMES = C_COUNTDOWN_FRAMES,
  parameter int LIFE_LOST_FRAMES = C_LIFE_LOST_FRAMES,
  parameter int FRAME_END_Y      = C_FRAME_END_Y
) (
  input wire               clk_100MHz,
  input wire               reset,
  game_flow_ctrl_if.slave  bus
);

  localparam logic [1:0] C_LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [2:0] C_LEVEL_MAX  = 3'(MAX_LEVEL);
  localparam logic [7:0] C_CD_LOAD    = 8'(COUNTDOWN_FRAMES);
  localparam logic [7:0] C_LL_LOAD    = 8'(LIFE_LOST_FRAMES);
  localparam logic [9:0] C_Y_END      = 10'(FRAME_END_Y);

  game_state_t r_state;
  logic [1:0]  r_lives;
  logic [2:0]  r_level;
  logic [7:0]  r_cnt;
  logic        r_game_reset;

  logic w_frame_tick;
  logic w_armed;
  logic w_hit;
  logic w_clr;

  assign w_frame_tick = bus.p_tick & (bus.x == 10'd0) & (bus.y == C_Y_END);
  assign w_armed      = (r_state == ST_PLAYING);

  frame_event_latch u_event_latch (
    .clk            (clk_100MHz),
    .rst            (reset),
    .i_frame_tick   (w_frame_tick),
    .i_armed        (w_armed),
    .i_player_hit   (bus.player_hit),
    .i_wave_cleared (bus.wave_cleared),
    .o_hit          (w_hit),
    .o_clr          (w_clr)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_state      <= ST_TITLE;
      r_lives      <= 2'd0;
      r_level      <= 3'd0;
      r_cnt        <= 8'd0;
      r_game_reset <= 1'b0;
    end else begin
      r_game_reset <= 1'b0;
      if (w_frame_tick) begin
        if (!bus.game_start && (r_state != ST_TITLE)) begin
          r_state <= ST_TITLE;
          r_lives <= 2'd0;
          r_level <= 3'd0;
          r_cnt   <= 8'd0;
        end else begin
          case (r_state)
            ST_TITLE: begin
              if (bus.game_start) begin
                r_state      <= ST_COUNTDOWN;
                r_lives      <= C_LIVES_LOAD;
                r_level      <= 3'd1;
                r_cnt        <= C_CD_LOAD;
                r_game_reset <= 1'b1;
              end
            end
            ST_COUNTDOWN: begin
              if (!bus.pause && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
                if (r_cnt == 8'd1) r_state <= ST_PLAYING;
              end
            end
            ST_PLAYING: begin
              // A hit outranks a clear landing in the same frame.
              if (w_hit) begin
                if (r_lives <= 2'd1) begin
                  r_state <= ST_GAME_OVER;
                  r_lives <= 2'd0;
                end else begin
                  r_state <= ST_LIFE_LOST;
                  r_lives <= r_lives - 2'd1;
                  r_cnt   <= C_LL_LOAD;
                end
              end else if (w_clr) begin
                if (r_level >= C_LEVEL_MAX) begin
                  r_state <= ST_WIN;
                end else begin
                  r_state      <= ST_COUNTDOWN;
                  r_level      <= r_level + 3'd1;
                  r_cnt        <= C_CD_LOAD;
                  r_game_reset <= 1'b1;
                end
              end else if (bus.pause) begin
                r_state <= ST_PAUSED;
              end
            end
            ST_PAUSED: begin
              if (!bus.pause) r_state <= ST_PLAYING;
            end
            ST_LIFE_LOST: begin
              // The wave resumes where it was, so no game_reset here.
              if (r_cnt == 8'd1) begin
                r_state <= ST_COUNTDOWN;
                r_cnt   <= C_CD_LOAD;
              end else if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign bus.screen_sel = screen_code(r_state);
  assign bus.game_run   = (r_state == ST_PLAYING);
  assign bus.game_reset = r_game_reset;
  assign bus.lives      = r_lives;
  assign bus.level      = r_level;
  assign bus.countdown  = r_cnt;
  assign bus.frame_tick = w_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_game_flow_ctrl: directed + random stimulus against a frame model   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_game_flow_ctrl;

  localparam int LIVES_I = 2;
  localparam int MAX_L   = 2;
  localparam int CD_F    = 3;
  localparam int LL_F    = 2;
  localparam int Y_END   = 481;

  localparam int SC_TITLE = 0;
  localparam int SC_CD    = 1;
  localparam int SC_PLAY  = 2;
  localparam int SC_PAUSE = 3;
  localparam int SC_LL    = 4;
  localparam int SC_WIN   = 5;
  localparam int SC_GO    = 6;

  logic clk;
  logic rst;

  game_flow_ctrl_if u_if ();

  game_flow_ctrl #(
    .LIVES_INIT       (LIVES_I),
    .MAX_LEVEL        (MAX_L),
    .COUNTDOWN_FRAMES (CD_F),
    .LIFE_LOST_FRAMES (LL_F),
    .FRAME_END_Y      (Y_END)
  ) u_dut (
    .clk_100MHz (clk),
    .reset      (rst),
    .bus        (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state, advanced once per clock from the rules.
  int m_scr, m_lives, m_level, m_cnt, m_gr;
  bit m_hf, m_cf;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rs, input bit ft, input bit gs, input bit ps,
                            input bit hit, input bit clr);
    bit h, c;
    m_gr = 0;
    if (rs) begin
      m_scr = SC_TITLE; m_lives = 0; m_level = 0; m_cnt = 0; m_hf = 0; m_cf = 0;
      return;
    end
    h = m_hf || (hit && m_scr == SC_PLAY);
    c = m_cf || (clr && m_scr == SC_PLAY);
    if (!ft) begin
      m_hf = h; m_cf = c;
      return;
    end
    m_hf = 0; m_cf = 0;
    if (!gs && m_scr != SC_TITLE) begin
      m_scr = SC_TITLE; m_level = 0; m_lives = 0; m_cnt = 0;
    end else if (m_scr == SC_TITLE) begin
      if (gs) begin
        m_scr = SC_CD; m_lives = LIVES_I; m_level = 1; m_cnt = CD_F; m_gr = 1;
      end
    end else if (m_scr == SC_CD) begin
      if (!ps) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_scr = SC_PLAY;
      end
    end else if (m_scr == SC_PLAY) begin
      if (h) begin
        if (m_lives == 1) begin
          m_scr = SC_GO; m_lives = 0;
        end else begin
          m_scr = SC_LL; m_lives = m_lives - 1; m_cnt = LL_F;
        end
      end else if (c) begin
        if (m_level == MAX_L) m_scr = SC_WIN;
        else begin
          m_level = m_level + 1; m_scr = SC_CD; m_cnt = CD_F; m_gr = 1;
        end
      end else if (ps) begin
        m_scr = SC_PAUSE;
      end
    end else if (m_scr == SC_PAUSE) begin
      if (!ps) m_scr = SC_PLAY;
    end else if (m_scr == SC_LL) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_scr = SC_CD; m_cnt = CD_F;
      end
    end
  endtask

  // One clock: drive, check the strobe, step the model, check registered outputs.
  task automatic cyc(input bit rs, input bit pt, input logic [9:0] xx, input logic [9:0] yy,
                     input bit gs, input bit ps, input bit hit, input bit clr);
    bit exp_ft;
    @(negedge clk);
    rst = rs;
    u_if.p_tick = pt; u_if.x = xx; u_if.y = yy;
    u_if.game_start = gs; u_if.pause = ps;
    u_if.player_hit = hit; u_if.wave_cleared = clr;
    #1;
    exp_ft = pt && (xx == 10'd0) && (int'(yy) == Y_END);
    chk("frame_tick", int'(u_if.frame_tick), int'(exp_ft));
    model_step(rs, exp_ft, gs, ps, hit, clr);
    @(posedge clk);
    #1;
    chk("screen_sel", int'(u_if.screen_sel), m_scr);
    chk("game_run",   int'(u_if.game_run), int'(m_scr == SC_PLAY));
    chk("game_reset", int'(u_if.game_reset), m_gr);
    chk("lives",      int'(u_if.lives), m_lives);
    chk("level",      int'(u_if.level), m_level);
    chk("countdown",  int'(u_if.countdown), m_cnt);
  endtask

  // One frame: two mid-frame cycles (with optional pulses), then the strobe cycle.
  task automatic frame(input bit gs, input bit ps, input bit hm, input bit cm, input bit ht);
    cyc(0, 1'b1, 10'($urandom_range(1, 639)), 10'($urandom_range(0, 524)), gs, ps, hm, cm);
    cyc(0, 1'b0, 10'd0, 10'(Y_END), gs, ps, 1'b0, 1'b0);
    cyc(0, 1'b1, 10'd0, 10'(Y_END), gs, ps, ht, 1'b0);
  endtask

  task automatic frames(input int n, input bit gs, input bit ps);
    for (int i = 0; i < n; i++) frame(gs, ps, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit gs_l, ps_l, rs_r, pt_r, hit_r, clr_r;
    logic [9:0] x_r, y_r;

    rst = 1'b1;
    u_if.p_tick = 0; u_if.x = 0; u_if.y = 0; u_if.game_start = 0; u_if.pause = 0;
    u_if.player_hit = 0; u_if.wave_cleared = 0;
    model_step(1, 0, 0, 0, 0, 0);

    cyc(1, 0, 10'd0, 10'd0, 0, 0, 0, 0);
    cyc(1, 1, 10'd0, 10'(Y_END), 1, 0, 0, 0);
    chk("rst_screen", int'(u_if.screen_sel), 0);
    chk("rst_lives", int'(u_if.lives), 0);

    // Game start and countdown into PLAYING.
    frame(1, 0, 0, 0, 0);
    chk("start_screen", int'(u_if.screen_sel), 1);
    chk("start_lives", int'(u_if.lives), 2);
    chk("start_level", int'(u_if.level), 1);
    chk("start_count", int'(u_if.countdown), 3);
    chk("start_greset", int'(u_if.game_reset), 1);
    frames(3, 1, 0);
    chk("play_screen", int'(u_if.screen_sel), 2);
    chk("play_run", int'(u_if.game_run), 1);

    // Life lost, back to playing, level clear, then game over.
    frame(1, 0, 1, 0, 0);
    chk("ll_screen", int'(u_if.screen_sel), 4);
    chk("ll_lives", int'(u_if.lives), 1);
    chk("ll_run", int'(u_if.game_run), 0);
    frames(2, 1, 0);
    chk("ll_to_cd", int'(u_if.screen_sel), 1);
    frames(3, 1, 0);
    chk("ll_to_play", int'(u_if.screen_sel), 2);
    frame(1, 0, 0, 1, 0);
    chk("clr_level", int'(u_if.level), 2);
    chk("clr_greset", int'(u_if.game_reset), 1);
    frames(3, 1, 0);
    frame(1, 0, 1, 0, 0);
    chk("go_screen", int'(u_if.screen_sel), 6);
    chk("go_lives", int'(u_if.lives), 0);
    frame(0, 0, 0, 0, 0);
    chk("abort_go", int'(u_if.screen_sel), 0);

    // Win path.
    frame(1, 0, 0, 0, 0); frames(3, 1, 0);
    frame(1, 0, 0, 1, 0); frames(3, 1, 0);
    frame(1, 0, 0, 1, 0);
    chk("win_screen", int'(u_if.screen_sel), 5);
    frame(0, 0, 0, 0, 0);

    // Hit on the strobe cycle beats an earlier clear in the same frame.
    frame(1, 0, 0, 0, 0); frames(3, 1, 0);
    frame(1, 0, 0, 1, 1);
    chk("sim_screen", int'(u_if.screen_sel), 4);
    chk("sim_level", int'(u_if.level), 1);
    chk("sim_lives", int'(u_if.lives), 1);

    // Pause in countdown, pause in play, abort while paused.
    frames(2, 1, 0);
    frame(1, 1, 0, 0, 0);
    chk("cd_hold", int'(u_if.countdown), 3);
    frames(3, 1, 0);
    frame(1, 1, 0, 0, 0);
    chk("paused", int'(u_if.screen_sel), 3);
    frame(1, 1, 1, 0, 0);
    chk("paused_hit", int'(u_if.screen_sel), 3);
    frame(1, 0, 0, 0, 0);
    chk("resume", int'(u_if.screen_sel), 2);
    chk("resume_lives", int'(u_if.lives), 1);
    frame(1, 1, 0, 0, 0);
    frame(0, 1, 0, 0, 0);
    chk("abort_pause", int'(u_if.screen_sel), 0);
    chk("abort_level", int'(u_if.level), 0);

    // Reset in LIFE_LOST without a frame strobe.
    frame(1, 0, 0, 0, 0); frames(3, 1, 0);
    frame(1, 0, 1, 0, 0);
    cyc(1, 0, 10'd5, 10'd100, 1, 0, 0, 0);
    chk("mid_rst_screen", int'(u_if.screen_sel), 0);
    chk("mid_rst_lives", int'(u_if.lives), 0);
    chk("mid_rst_count", int'(u_if.countdown), 0);

    // Randomized traffic against the model.
    gs_l = 1; ps_l = 0;
    for (int n = 0; n < 4000; n++) begin
      rs_r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 2) gs_l = ~gs_l;
      if (!gs_l && $urandom_range(0, 9) == 0) gs_l = 1;
      if ($urandom_range(0, 99) < 6) ps_l = ~ps_l;
      if ($urandom_range(0, 4) == 0) begin
        pt_r = 1; x_r = 10'd0; y_r = 10'(Y_END);
      end else begin
        pt_r = ($urandom_range(0, 3) == 0);
        x_r  = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(0, 799));
        y_r  = ($urandom_range(0, 3) == 0) ? 10'(Y_END) : 10'($urandom_range(0, 524));
      end
      hit_r = ($urandom_range(0, 99) < 4);
      clr_r = ($urandom_range(0, 99) < 5);
      cyc(rs_r, pt_r, x_r, y_r, gs_l, ps_l, hit_r, clr_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
